// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit: op codes and FSM states.
package muldiv_pkg;

    localparam logic [2:0] MD_MULT  = 3'b000;
    localparam logic [2:0] MD_MULTU = 3'b001;
    localparam logic [2:0] MD_DIV   = 3'b010;
    localparam logic [2:0] MD_DIVU  = 3'b011;
    localparam logic [2:0] MD_MTHI  = 3'b100;
    localparam logic [2:0] MD_MTLO  = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    // Ops that run through CALC/FIX; op[0] clear marks the signed variants.
    function automatic logic is_iter_op(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Shift/add-subtract datapath: one radix-2 multiply or restoring-divide step per enable
// on a 2*WIDTH accumulator. Operands arrive as unsigned magnitudes.
module muldiv_iter #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic                 step,
    input  logic                 div_mode,
    input  logic [WIDTH-1:0]     a_mag,
    input  logic [WIDTH-1:0]     b_mag,
    output logic [2*WIDTH-1:0]   acc
);

    logic [WIDTH-1:0]   opnd;
    logic               div_q;
    logic [2*WIDTH-1:0] acc_next;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH:0]     diff;

    always_comb begin
        // NOTE: every signal gets a default first so no branch can infer a latch.
        acc_next = acc;
        sum      = '0;
        rem_sh   = '0;
        diff     = '0;
        if (div_q) begin
            // Partial remainder shifted left; the extra top bit avoids losing the carry-out.
            rem_sh = acc[2*WIDTH-1:WIDTH-1];
            diff   = rem_sh - {1'b0, opnd};
            if (!diff[WIDTH])
                acc_next = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            else
                acc_next = {acc[2*WIDTH-2:0], 1'b0};
        end else begin
            sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
            acc_next = {sum, acc[WIDTH-1:1]};
        end
    end

    // NOTE: clocked state uses non-blocking assignments so all registers sample pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc   <= '0;
            opnd  <= '0;
            div_q <= 1'b0;
        end else if (load) begin
            div_q <= div_mode;
            opnd  <= div_mode ? b_mag : a_mag;
            acc   <= {{WIDTH{1'b0}}, (div_mode ? a_mag : b_mag)};
        end else if (step) begin
            acc   <= acc_next;
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with architectural HI/LO; start/busy/done handshake,
// WIDTH CALC cycles plus one FIX cycle for sign correction and the HI/LO write.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    state_t             state;
    logic [CW-1:0]      cnt;
    logic               sign_res;
    logic               sign_rem;
    logic               is_div;
    logic               div0;

    logic               issue;
    logic               iter_issue;
    logic               signed_op;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   hi_fix;
    logic [WIDTH-1:0]   lo_fix;

    always_comb begin
        issue      = start && !busy && !flush;
        iter_issue = issue && is_iter_op(op);
        signed_op  = !op[0];
        a_mag      = (signed_op && a[WIDTH-1]) ? -a : a;
        b_mag      = (signed_op && b[WIDTH-1]) ? -b : b;
        hi_fix     = acc[2*WIDTH-1:WIDTH];
        lo_fix     = acc[WIDTH-1:0];
        if (is_div) begin
            // With b=0 the remainder holds |a|; its sign correction restores a exactly.
            hi_fix = sign_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
            lo_fix = div0 ? {WIDTH{1'b1}} : (sign_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0]);
        end else if (sign_res) begin
            {hi_fix, lo_fix} = -acc;
        end
    end

    muldiv_iter #(.WIDTH(WIDTH)) u_iter (
        .clk      (clk),
        .reset    (reset),
        .load     (iter_issue),
        .step     (state == CALC),
        .div_mode (op[1]),
        .a_mag    (a_mag),
        .b_mag    (b_mag),
        .acc      (acc)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            cnt      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            sign_res <= 1'b0;
            sign_rem <= 1'b0;
            is_div   <= 1'b0;
            div0     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (flush) begin
                state <= IDLE;
                busy  <= 1'b0;
                cnt   <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start && !busy) begin
                            case (op)
                                MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
                                    state    <= CALC;
                                    busy     <= 1'b1;
                                    cnt      <= CW'(WIDTH - 1);
                                    is_div   <= op[1];
                                    div0     <= (b == '0);
                                    sign_res <= signed_op && (a[WIDTH-1] ^ b[WIDTH-1]);
                                    sign_rem <= signed_op && a[WIDTH-1];
                                end
                                MD_MTHI: begin
                                    hi   <= a;
                                    done <= 1'b1;
                                end
                                MD_MTLO: begin
                                    lo   <= a;
                                    done <= 1'b1;
                                end
                                default: ;
                            endcase
                        end
                    end
                    CALC: begin
                        if (cnt == '0)
                            state <= FIX;
                        else
                            cnt <= cnt - 1'b1;
                    end
                    FIX: begin
                        hi    <= hi_fix;
                        lo    <= lo_fix;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit (WIDTH=32): a cycle-level arithmetic model checked every
// cycle, plus hand-computed literal results, latencies and handshake expectations.
module tb_muldiv_unit;

    localparam int W = 32;

    logic         clk   = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic         flush = 1'b0;
    logic [2:0]   op    = 3'b000;
    logic [W-1:0] a     = '0;
    logic [W-1:0] b     = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int checks = 0;
    int errors = 0;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .flush (flush),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Architectural result {hi, lo} from plain 64-bit arithmetic.
    function automatic logic [63:0] ref_result(input logic [2:0] o, input logic [31:0] x,
                                                input logic [31:0] y);
        longint          sx, sy, q, r;
        longint unsigned ux, uy;
        logic   [63:0]   res;
        sx = $signed(x);
        sy = $signed(y);
        ux = {32'd0, x};
        uy = {32'd0, y};
        res = '0;
        case (o)
            3'b000: res = sx * sy;
            3'b001: res = ux * uy;
            3'b010, 3'b011: begin
                if (y == 32'd0) begin
                    res = {x, 32'hFFFF_FFFF};
                end else if (o == 3'b010) begin
                    q = sx / sy;
                    r = sx % sy;
                    res = {r[31:0], q[31:0]};
                end else begin
                    res = {32'(ux % uy), 32'(ux / uy)};
                end
            end
            default: res = '0;
        endcase
        return res;
    endfunction

    // Reference timing: result lands W+1 edges after the issue edge.
    int          remaining = 0;
    logic [63:0] pend      = '0;
    logic        m_busy    = 1'b0;
    logic        m_done    = 1'b0;
    logic [31:0] m_hi      = '0;
    logic [31:0] m_lo      = '0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            remaining = 0;
            m_busy    = 1'b0;
            m_done    = 1'b0;
            m_hi      = '0;
            m_lo      = '0;
        end else begin
            m_done = 1'b0;
            if (flush) begin
                remaining = 0;
            end else if (remaining > 0) begin
                remaining--;
                if (remaining == 0) begin
                    {m_hi, m_lo} = pend;
                    m_done = 1'b1;
                end
            end else if (start) begin
                case (op)
                    3'b000, 3'b001, 3'b010, 3'b011: begin
                        pend      = ref_result(op, a, b);
                        remaining = W + 1;
                    end
                    3'b100: begin m_hi = a; m_done = 1'b1; end
                    3'b101: begin m_lo = a; m_done = 1'b1; end
                    default: ;
                endcase
            end
            m_busy = (remaining > 0);
        end
    end

    always @(negedge clk) begin
        check("busy", {63'd0, busy}, {63'd0, m_busy});
        check("done", {63'd0, done}, {63'd0, m_done});
        check("hi", {32'd0, hi}, {32'd0, m_hi});
        check("lo", {32'd0, lo}, {32'd0, m_lo});
    end

    // Drives one issue; b2b drives immediately (caller sits in the done cycle).
    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         input bit b2b);
        if (!b2b) begin
            @(posedge clk);
            #2;
        end
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(posedge clk);
        #2;
        start = 1'b0;
    endtask

    // n0 = negedges already elapsed since the issue edge; returns in the done cycle.
    task automatic wait_done(input string nm, input int n0, input logic [31:0] eh,
                             input logic [31:0] el);
        int n, bc;
        n  = n0;
        bc = n0;
        while (n < 100) begin
            @(negedge clk);
            n++;
            if (done) break;
            if (busy) bc++;
        end
        check({nm, " latency"}, 64'(n - 1), 64'd33);
        check({nm, " busy cycles"}, 64'(bc), 64'd33);
        check({nm, " hi"}, {32'd0, hi}, {32'd0, eh});
        check({nm, " lo"}, {32'd0, lo}, {32'd0, el});
    endtask

    initial begin
        int dcount;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset busy", {63'd0, busy}, 64'd0);
        check("reset done", {63'd0, done}, 64'd0);
        check("reset hi", {32'd0, hi}, 64'd0);
        check("reset lo", {32'd0, lo}, 64'd0);
        @(posedge clk);
        #2 reset = 1'b1;

        issue(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        wait_done("multu max", 0, 32'hFFFF_FFFE, 32'h0000_0001);
        issue(3'b000, 32'hFFFF_FFFD, 32'd7, 1'b0);
        wait_done("mult -3x7", 0, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        issue(3'b000, 32'h8000_0000, 32'h8000_0000, 1'b0);
        wait_done("mult min^2", 0, 32'h4000_0000, 32'h0000_0000);
        issue(3'b011, 32'd100, 32'd7, 1'b0);
        wait_done("divu 100/7", 0, 32'd2, 32'd14);
        issue(3'b010, 32'hFFFF_FFF9, 32'd2, 1'b0);
        wait_done("div -7/2", 0, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        issue(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        wait_done("div min/-1", 0, 32'h0000_0000, 32'h8000_0000);
        issue(3'b010, 32'h1234_5678, 32'd0, 1'b0);
        wait_done("div by zero", 0, 32'h1234_5678, 32'hFFFF_FFFF);

        // Issue straight from the done cycle.
        issue(3'b011, 32'hFFFF_FFFF, 32'h0000_0010, 1'b1);
        wait_done("divu b2b", 0, 32'h0000_000F, 32'h0FFF_FFFF);

        issue(3'b100, 32'hDEAD_BEEF, 32'd0, 1'b0);
        @(negedge clk);
        check("mthi hi", {32'd0, hi}, {32'd0, 32'hDEAD_BEEF});
        check("mthi lo kept", {32'd0, lo}, {32'd0, 32'h0FFF_FFFF});
        check("mthi done", {63'd0, done}, 64'd1);
        check("mthi busy", {63'd0, busy}, 64'd0);
        @(negedge clk);
        check("mthi done pulse", {63'd0, done}, 64'd0);
        issue(3'b101, 32'h1357_9BDF, 32'd0, 1'b0);
        @(negedge clk);
        check("mtlo lo", {32'd0, lo}, {32'd0, 32'h1357_9BDF});
        check("mtlo hi kept", {32'd0, hi}, {32'd0, 32'hDEAD_BEEF});

        issue(3'b110, 32'hAAAA_AAAA, 32'd1, 1'b0);
        @(negedge clk);
        check("reserved done", {63'd0, done}, 64'd0);
        check("reserved busy", {63'd0, busy}, 64'd0);

        // Start with new operands during CALC is ignored.
        issue(3'b001, 32'h0001_0000, 32'h0001_0000, 1'b0);
        repeat (5) @(posedge clk);
        #2;
        start = 1'b1; op = 3'b000; a = 32'd5; b = 32'd5;
        @(posedge clk);
        #2 start = 1'b0;
        wait_done("ignored start", 6, 32'h0000_0001, 32'h0000_0000);

        // Flush mid-CALC: no done, HI/LO untouched.
        issue(3'b011, 32'd1000, 32'd3, 1'b0);
        repeat (10) @(posedge clk);
        #2 flush = 1'b1;
        @(posedge clk);
        #2 flush = 1'b0;
        @(negedge clk);
        check("flush busy", {63'd0, busy}, 64'd0);
        dcount = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) dcount++;
        end
        check("flush no done", 64'(dcount), 64'd0);
        check("flush hi", {32'd0, hi}, 64'd1);
        check("flush lo", {32'd0, lo}, 64'd0);

        // Flush wins over a simultaneous start.
        @(posedge clk);
        #2;
        flush = 1'b1; start = 1'b1; op = 3'b100; a = 32'h5555_5555;
        @(posedge clk);
        #2;
        flush = 1'b0; start = 1'b0;
        @(negedge clk);
        check("flush+start hi", {32'd0, hi}, 64'd1);
        check("flush+start done", {63'd0, done}, 64'd0);

        // Asynchronous reset mid-CALC.
        issue(3'b001, 32'd7, 32'd9, 1'b0);
        repeat (8) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check("async reset busy", {63'd0, busy}, 64'd0);
        check("async reset hi", {32'd0, hi}, 64'd0);
        check("async reset lo", {32'd0, lo}, 64'd0);
        @(posedge clk);
        #2 reset = 1'b1;
        issue(3'b001, 32'd7, 32'd9, 1'b0);
        wait_done("multu after reset", 0, 32'd0, 32'd63);

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Parametrised iterative multiply/divide unit with architectural HI/LO registers, replacing the single-cycle combinational MUL/MFHI/MFLO path in the ALU. It sits beside the ALU in the execute stage. The controller issues operations over a start/busy/done handshake. HI/LO are read directly from the outputs for MFHI/MFLO. It supports signed and unsigned multiply and divide plus direct HI/LO writes, and it can be aborted with a flush.

## Interface
Parameters:
- `WIDTH`, default 32: operand width and width of each of HI/LO; must be ≥ 4.

Ports:
- `clk`: input, 1 bit. Rising-edge clock.
- `reset`: input, 1 bit. Asynchronous, active-low reset.
- `start`: input, 1 bit. Issue request, sampled on a rising edge.
- `op`: input, 3 bits. Operation, using `muldiv_pkg` encoding.
- `a`: input, WIDTH bits. rs operand: multiplicand or dividend. Also the source for MTHI/MTLO.
- `b`: input, WIDTH bits. rt operand: multiplier or divisor.
- `flush`: input, 1 bit. Aborts any in-flight operation.
- `busy`: output, 1 bit. High while an iterative operation is in flight.
- `done`: output, 1 bit. One-cycle pulse when HI/LO have just been written.
- `hi`: output, WIDTH bits. HI register (product upper half / remainder).
- `lo`: output, WIDTH bits. LO register (product lower half / quotient).

## Operation
- Op encodings: MULT=000, MULTU=001, DIV=010, DIVU=011, MTHI=100, MTLO=101. Encodings 110 and 111 are reserved: no effect, no `done`.
- FSM states:
  - IDLE: waits for an issue.
  - CALC: runs exactly WIDTH iterations, counted by a down-counter.
  - FIX: one cycle of sign correction and HI/LO write.
  - After FIX the FSM returns to IDLE.
- Issue: `start`=1, `busy`=0 and `flush`=0 at a rising edge.
  - Iterative ops latch the operands, record the sign flags, and enter CALC.
  - `start` while `busy`=1 is ignored. Operands are not re-sampled.
- Signed ops convert operands to magnitudes at issue.
  - Sign flags: product sign = sa^sb; quotient sign = sa^sb; remainder sign = sa.
  - FIX applies two's-complement negation as needed, mod 2^WIDTH.
- Multiply: radix-2 shift-add on a 2·WIDTH-bit accumulator. The result is the full 2·WIDTH-bit product, HI = upper half, LO = lower half.
- Divide: restoring, one quotient bit per CALC cycle.
  - Signed quotient truncates toward zero.
  - Signed MIN / −1 gives LO = MIN, HI = 0, with no exception.
- Divide by zero (b = 0, signed or unsigned): LO = all ones, HI = `a` unmodified. Timing is unchanged, and no sign correction is applied.
- MTHI/MTLO: a single-cycle write of `a` to HI or LO on the issue edge. `done` pulses in the following cycle and `busy` stays 0. The other register is unchanged.
- `flush`=1 at an edge:
  - FSM returns to IDLE; `busy` deasserts in the next cycle.
  - No `done`; HI/LO keep their pre-issue values.
  - `flush` wins over a simultaneous `start`.
- HI/LO are written only in FIX, or on MTHI/MTLO issue. They hold their value at all other times, and at no point do they show partial results.

## Timing
- Reset (`reset`=0, asynchronous):
  - State = IDLE; `busy`=0, `done`=0, `hi`=0, `lo`=0; counter = 0.
  - Reset mid-operation discards the operation.
- Iterative latency: issue at edge E0.
  - `busy`=1 from after E0 through E(WIDTH+1).
  - At E(WIDTH+1), HI/LO are written, `busy` falls and `done`=1 for one cycle.
  - Total issue-to-done latency is WIDTH+1 clocks (33 for WIDTH=32).
- Back-to-back: `start` in the `done` cycle is accepted, because `busy`=0 there.
- Counter: counts WIDTH−1 down to 0, with width `$clog2(WIDTH)`. No wrap beyond 0; CALC→FIX happens at 0.

## Structure
- `muldiv_pkg` holds:
  - the op encodings (`MD_MULT` … `MD_MTLO`);
  - the FSM state enum (IDLE, CALC, FIX).
- Sub-module `muldiv_iter` contains the shift/add-subtract datapath: a 2·WIDTH-bit accumulator plus one iteration step per enable.
- The top level owns the FSM, counter, sign flags, FIX negation and the HI/LO registers.

## Test plan
All scenarios use WIDTH=32.
- **MULTU:** 0xFFFFFFFF × 0xFFFFFFFF → `hi`=0xFFFFFFFE, `lo`=0x00000001. `done` arrives exactly 33 clocks after issue, and `busy` is high for 33 cycles.
- **MULT:** −3 × 7 → `hi`=0xFFFFFFFF, `lo`=0xFFFFFFEB. Then MULT 0x80000000 × 0x80000000 → `hi`=0x40000000, `lo`=0.
- **Divide:**
  - DIVU 100 / 7 → `lo`=14, `hi`=2.
  - DIV −7 / 2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF.
  - DIV 0x80000000 / 0xFFFFFFFF → `lo`=0x80000000, `hi`=0.
- **Divide by zero:** DIV 0x12345678 / 0 → `lo`=0xFFFFFFFF, `hi`=0x12345678 after 33 clocks.
- **MTHI / MTLO:** MTHI 0xDEADBEEF → `hi` updated the next cycle, `done` pulses once, `busy` never rises. MTLO then leaves `hi` intact.
- **Abort and ignored starts:**
  - `start` with new operands at CALC cycle 5 is ignored and the result is unchanged.
  - `flush` at CALC cycle 10 → `busy`=0 the next cycle, no `done`, HI/LO hold their prior values.
  - `reset` low mid-CALC → immediately `busy`=0, `hi`=`lo`=0.
